// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: datapath widths, the x0 address and the
// writeback select encodings driven into mux_writeback.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'b00,
        WB_SEL_MEM = 2'b01,
        WB_SEL_PC4 = 2'b10,
        WB_SEL_IMM = 2'b11
    } mem_to_reg_e;

endpackage

// File: rtl/reg_read_port.sv
// One combinational register read port: x0 forces zero, an optional bypass
// returns the in-flight writeback value, otherwise the array entry is selected.
module reg_read_port
    import riscv_pkg::*;
#(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W,
    parameter int BYPASS_EN  = 1
) (
    input  logic                                      rst_n,
    input  logic                                      reg_write,
    input  logic [REG_ADDR_W-1:0]                     rd_addr,
    input  logic [XLEN-1:0]                           write_data,
    input  logic [REG_ADDR_W-1:0]                     addr,
    input  logic [(2**REG_ADDR_W)-1:0][XLEN-1:0]      array_vals,
    output logic [XLEN-1:0]                           data
);

    logic bypass_hit_s;

    // Bypass is suppressed during reset so every port reads zero while rst_n is low.
    always_comb begin
        bypass_hit_s = 1'b0;
        if ((BYPASS_EN != 0) && rst_n && reg_write && (rd_addr == addr)) begin
            bypass_hit_s = 1'b1;
        end else begin
            bypass_hit_s = 1'b0;
        end
    end

    // Read mux: address zero first, then bypass, then stored value.
    always_comb begin
        data = {XLEN{1'b0}};
        if (addr == REG_ADDR_W'(REG_X0)) begin
            data = {XLEN{1'b0}};
        end else if (bypass_hit_s) begin
            data = write_data;
        end else begin
            data = array_vals[addr];
        end
    end

endmodule

// File: rtl/reg_file.sv
// RV32I integer register file: x1..x31 in flops, x0 hardwired to zero,
// three combinational read ports (rs1, rs2, debug) and a committed-write counter.
module reg_file
    import riscv_pkg::*;
#(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W,
    parameter int BYPASS_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]       write_data,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [XLEN-1:0]       dbg_data,
    output logic [31:0]           write_count
);

    localparam int NREG = 2**REG_ADDR_W;

    logic [NREG-1:1][XLEN-1:0] regs_q;
    logic [NREG-1:1][XLEN-1:0] regs_d;
    logic [31:0]               write_count_q;
    logic [31:0]               write_count_d;
    logic                      commit_s;
    logic [NREG-1:0][XLEN-1:0] array_s;

    // Next-state for the array and counter; writes to x0 are dropped entirely.
    always_comb begin
        regs_d        = regs_q;
        write_count_d = write_count_q;
        commit_s      = 1'b0;
        if (reg_write && (rd_addr != REG_ADDR_W'(REG_X0))) begin
            commit_s      = 1'b1;
            write_count_d = write_count_q + 32'd1;
        end else begin
            commit_s      = 1'b0;
            write_count_d = write_count_q;
        end
        for (int i = 1; i < NREG; i++) begin
            if (commit_s && (rd_addr == REG_ADDR_W'(i))) begin
                regs_d[i] = write_data;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Array and counter state; reset clears everything without a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q        <= '0;
            write_count_q <= 32'd0;
        end else begin
            regs_q        <= regs_d;
            write_count_q <= write_count_d;
        end
    end

    assign array_s     = {regs_q, {XLEN{1'b0}}};
    assign write_count = write_count_q;

    reg_read_port #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W),
        .BYPASS_EN  (BYPASS_EN)
    ) u_rs1_port (
        .rst_n      (rst_n),
        .reg_write  (reg_write),
        .rd_addr    (rd_addr),
        .write_data (write_data),
        .addr       (rs1_addr),
        .array_vals (array_s),
        .data       (rs1_data)
    );

    reg_read_port #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W),
        .BYPASS_EN  (BYPASS_EN)
    ) u_rs2_port (
        .rst_n      (rst_n),
        .reg_write  (reg_write),
        .rd_addr    (rd_addr),
        .write_data (write_data),
        .addr       (rs2_addr),
        .array_vals (array_s),
        .data       (rs2_data)
    );

    reg_read_port #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W),
        .BYPASS_EN  (BYPASS_EN)
    ) u_dbg_port (
        .rst_n      (rst_n),
        .reg_write  (reg_write),
        .rd_addr    (rd_addr),
        .write_data (write_data),
        .addr       (dbg_addr),
        .array_vals (array_s),
        .data       (dbg_data)
    );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: a bypassing and a non-bypassing instance share
// the same stimulus; expectations are queued and checked by a monitor process.
module tb_reg_file;
    import riscv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic [31:0] write_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  dbg_addr;

    logic [31:0] rs1_b, rs2_b, dbg_b, wc_b;
    logic [31:0] rs1_n, rs2_n, dbg_n, wc_n;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    event     sample_ev;
    int       checks = 0;
    int       errors = 0;

    localparam int S_RS1_B = 0, S_RS2_B = 1, S_DBG_B = 2, S_WC_B = 3;
    localparam int S_RS1_N = 4, S_RS2_N = 5, S_DBG_N = 6, S_WC_N = 7;

    reg_file #(.XLEN(32), .REG_ADDR_W(5), .BYPASS_EN(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .rd_addr(rd_addr),
        .write_data(write_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_b), .rs2_data(rs2_b), .dbg_addr(dbg_addr),
        .dbg_data(dbg_b), .write_count(wc_b)
    );

    reg_file #(.XLEN(32), .REG_ADDR_W(5), .BYPASS_EN(0)) u_nb (
        .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .rd_addr(rd_addr),
        .write_data(write_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_n), .rs2_data(rs2_n), .dbg_addr(dbg_addr),
        .dbg_data(dbg_n), .write_count(wc_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            S_RS1_B: pick = rs1_b;
            S_RS2_B: pick = rs2_b;
            S_DBG_B: pick = dbg_b;
            S_WC_B:  pick = wc_b;
            S_RS1_N: pick = rs1_n;
            S_RS2_N: pick = rs2_n;
            S_DBG_N: pick = dbg_n;
            S_WC_N:  pick = wc_n;
            default: pick = 32'hxxxx_xxxx;
        endcase
    endfunction

    // Writeback selection as mux_writeback drives it.
    function automatic logic [31:0] wb_mux(input mem_to_reg_e sel, input logic [31:0] alu,
                                           input logic [31:0] mem, input logic [31:0] pc4,
                                           input logic [31:0] imm);
        case (sel)
            WB_SEL_ALU: wb_mux = alu;
            WB_SEL_MEM: wb_mux = mem;
            WB_SEL_PC4: wb_mux = pc4;
            WB_SEL_IMM: wb_mux = imm;
            default:    wb_mux = 32'd0;
        endcase
    endfunction

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
        sb_item_t it;
        it.name = name;
        it.sel  = sel;
        it.exp  = exp;
        sb_q.push_back(it);
    endtask

    task automatic sample();
        #1;
        -> sample_ev;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: drain all queued expectations whenever outputs are presented.
    initial begin
        sb_item_t    it;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                it  = sb_q.pop_front();
                act = pick(it.sel);
                checks++;
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] wb_exp [4];
        wb_exp[0] = 32'hAAAA_AAAA;
        wb_exp[1] = 32'hBBBB_BBBB;
        wb_exp[2] = 32'hCCCC_CCCC;
        wb_exp[3] = 32'hDDDD_DDDD;

        // Reset held with a pending write
        rst_n = 1'b0; reg_write = 1'b1; rd_addr = 5'd5; write_data = 32'hAAAA_AAAA;
        rs1_addr = 5'd5; rs2_addr = 5'd5; dbg_addr = 5'd5;
        repeat (3) tick();
        expect_val("rst_rs1_byp", S_RS1_B, 32'd0);
        expect_val("rst_wc", S_WC_B, 32'd0);
        expect_val("rst_dbg_nb", S_DBG_N, 32'd0);
        sample();
        rst_n = 1'b1;
        expect_val("release_bypass", S_RS1_B, 32'hAAAA_AAAA);
        expect_val("release_nb_old", S_RS1_N, 32'd0);
        sample();
        tick();
        reg_write = 1'b0;
        expect_val("x5_byp", S_RS1_B, 32'hAAAA_AAAA);
        expect_val("x5_nb", S_RS1_N, 32'hAAAA_AAAA);
        expect_val("wc_after_release", S_WC_B, 32'd1);
        sample();

        // x0 guard
        reg_write = 1'b1; rd_addr = 5'd0; write_data = 32'hDEAD_BEEF;
        rs1_addr = 5'd0; rs2_addr = 5'd0; dbg_addr = 5'd0;
        expect_val("x0_rs1_same", S_RS1_B, 32'd0);
        expect_val("x0_rs2_same", S_RS2_B, 32'd0);
        expect_val("x0_dbg_same", S_DBG_B, 32'd0);
        sample();
        tick();
        reg_write = 1'b0;
        expect_val("x0_rs1_after", S_RS1_B, 32'd0);
        expect_val("x0_wc_byp", S_WC_B, 32'd1);
        expect_val("x0_wc_nb", S_WC_N, 32'd1);
        sample();

        // Same-cycle bypass vs. old value
        reg_write = 1'b1; rd_addr = 5'd7; write_data = 32'h1111_1111;
        rs1_addr = 5'd3; rs2_addr = 5'd3;
        tick();
        write_data = 32'h2222_2222; rs1_addr = 5'd7; rs2_addr = 5'd7;
        expect_val("byp_rs1", S_RS1_B, 32'h2222_2222);
        expect_val("byp_rs2", S_RS2_B, 32'h2222_2222);
        expect_val("nb_rs1_old", S_RS1_N, 32'h1111_1111);
        expect_val("nb_rs2_old", S_RS2_N, 32'h1111_1111);
        sample();
        tick();
        reg_write = 1'b0;
        expect_val("nb_rs1_new", S_RS1_N, 32'h2222_2222);
        expect_val("byp_rs2_new", S_RS2_B, 32'h2222_2222);
        expect_val("wc_after_x7", S_WC_B, 32'd3);
        sample();

        // Async reset between edges
        reg_write = 1'b1; rd_addr = 5'd3; write_data = 32'hBBBB_BBBB; dbg_addr = 5'd3;
        tick();
        reg_write = 1'b0;
        expect_val("x3_dbg_byp", S_DBG_B, 32'hBBBB_BBBB);
        expect_val("x3_dbg_nb", S_DBG_N, 32'hBBBB_BBBB);
        sample();
        #2;
        rst_n = 1'b0;
        expect_val("async_dbg_byp", S_DBG_B, 32'd0);
        expect_val("async_dbg_nb", S_DBG_N, 32'd0);
        expect_val("async_x7", S_RS1_B, 32'd0);
        expect_val("async_wc", S_WC_B, 32'd0);
        sample();
        #1;
        rst_n = 1'b1;

        // Back-to-back writes
        tick();
        reg_write = 1'b1; rd_addr = 5'd1; write_data = 32'hCCCC_CCCC;
        tick();
        rd_addr = 5'd2; write_data = 32'hDDDD_DDDD;
        tick();
        reg_write = 1'b0; rs1_addr = 5'd1; rs2_addr = 5'd2;
        expect_val("b2b_x1", S_RS1_B, 32'hCCCC_CCCC);
        expect_val("b2b_x2", S_RS2_B, 32'hDDDD_DDDD);
        expect_val("b2b_x2_nb", S_RS2_N, 32'hDDDD_DDDD);
        expect_val("b2b_wc", S_WC_B, 32'd2);
        expect_val("b2b_wc_nb", S_WC_N, 32'd2);
        sample();

        // Writeback integration: each select routes a different source
        for (int i = 0; i < 4; i++) begin
            tick();
            reg_write  = 1'b1;
            rd_addr    = 5'(10 + i);
            write_data = wb_mux(mem_to_reg_e'(i), 32'hAAAA_AAAA, 32'hBBBB_BBBB,
                                32'hCCCC_CCCC, 32'hDDDD_DDDD);
        end
        tick();
        reg_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rs1_addr = 5'(10 + i);
            expect_val($sformatf("wb_x%0d_byp", 10 + i), S_RS1_B, wb_exp[i]);
            expect_val($sformatf("wb_x%0d_nb", 10 + i), S_RS1_N, wb_exp[i]);
            sample();
        end
        rs1_addr = 5'd12; rs2_addr = 5'd12; dbg_addr = 5'd12;
        expect_val("same_addr_rs1", S_RS1_B, 32'hCCCC_CCCC);
        expect_val("same_addr_rs2", S_RS2_B, 32'hCCCC_CCCC);
        expect_val("same_addr_dbg", S_DBG_B, 32'hCCCC_CCCC);
        expect_val("wb_wc", S_WC_B, 32'd6);
        sample();

        tick();
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Integer register file of the RV32I pipeline, directly downstream of `mux_writeback`. It consumes the selected `write_data` and the WB-stage `reg_write`/`rd` controls, and supplies operands to the decode stage. It holds 32 × 32-bit registers with x0 hardwired to zero. An optional write-to-read bypass lets the decode stage see a value written back in the same cycle without a separate forwarding path.

## Interface
Parameters:
- `XLEN`, 32, data width of each register
- `REG_ADDR_W`, 5, register address width (2^REG_ADDR_W registers)
- `BYPASS_EN`, 1, 1 = same-cycle write-to-read bypass on all read ports; 0 = reads return array contents only

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `reg_write`  in  1  WB-stage write enable
- `rd_addr`  in  REG_ADDR_W  WB destination register
- `write_data`  in  XLEN  value from `mux_writeback`
- `rs1_addr`  in  REG_ADDR_W  decode read port 1 address
- `rs2_addr`  in  REG_ADDR_W  decode read port 2 address
- `rs1_data`  out  XLEN  read port 1 data (combinational)
- `rs2_data`  out  XLEN  read port 2 data (combinational)
- `dbg_addr`  in  REG_ADDR_W  debug/testbench read address
- `dbg_data`  out  XLEN  debug read data (combinational, same rules as rs ports)
- `write_count`  out  32  number of committed writes since reset, excluding writes to x0

## Operation
- Storage: registers x1..x31 as flops; x0 is not stored.
- Write: on rising `clk`, if `rst_n`=1, `reg_write`=1 and `rd_addr`≠0, then `reg[rd_addr]` ← `write_data` and `write_count` increments by 1.
- Any write with `rd_addr`=0 is discarded and does not increment `write_count`.
- Read (each of rs1, rs2, dbg, independently):
  - address 0 → 0.
  - Else, if `BYPASS_EN`=1, `rst_n`=1, `reg_write`=1 and `rd_addr`=address → `write_data`.
  - Else → `reg[address]`.
- Any read port may use the same address as another port, and each returns the identical value.
- `write_count` wraps from 0xFFFFFFFF to 0 with no flag.
- Reset: while `rst_n`=0, all registers and `write_count` are 0 and bypass is suppressed, so all read outputs are 0.
  - Asserting reset mid-operation clears state immediately, without waiting for a clock edge.
  - A write presented in the same cycle that reset deasserts commits on the next rising edge.

## Timing
- Write latency: 1 clock. The value is visible from the array on the cycle after the edge.
- With `BYPASS_EN`=1, the value is also visible on a matching read port in the write cycle itself (0-cycle read-after-write).
- With `BYPASS_EN`=0, a same-cycle read of the register being written returns the old value.
- Read path is purely combinational from the address, array and bypass inputs; there are no read-side flops.
- Reset values: `rs1_data`=`rs2_data`=`dbg_data`=0, `write_count`=0, and all registers are 0.
- No handshake: `reg_write` is a single-cycle qualifier, and back-to-back writes on consecutive cycles are supported.

## Structure
- Shared package `riscv_pkg`: `XLEN`, `REG_ADDR_W`, `REG_X0` (5'd0), and the `mem_to_reg` select encodings used by `mux_writeback`.
  - The encodings are 00 ALU, 01 MEM, 10 PC+4, 11 IMM.
- One sub-module, `reg_read_port`: address-zero check, bypass compare and array select. It is instantiated three times (rs1, rs2, dbg) with `BYPASS_EN` passed through.
- Array and write logic live in `reg_file` itself.

## Test plan
- Reset: hold `rst_n`=0 and drive `reg_write`=1, `rd_addr`=5, `write_data`=0xAAAAAAAA for 3 edges → `rs1_data`(addr 5)=0 and `write_count`=0. After release plus one edge, x5 reads 0xAAAAAAAA and `write_count`=1.
- x0 guard: write 0xDEADBEEF to rd=0 → `rs1_data`/`rs2_data`/`dbg_data` at addr 0 all read 0, and `write_count` is unchanged.
- Bypass, `BYPASS_EN`=1: x7=0x11111111 is committed, then in the next cycle write 0x22222222 to rd=7 with `rs1_addr`=`rs2_addr`=7.
  - Same cycle → both ports read 0x22222222.
  - Same scenario with `BYPASS_EN`=0 → 0x11111111 until the edge, then 0x22222222.
- Back-to-back writes: consecutive-cycle writes x1=0xCCCCCCCC and x2=0xDDDDDDDD, with `rs1_addr`=1 and `rs2_addr`=2 read afterwards → 0xCCCCCCCC and 0xDDDDDDDD; `write_count`=2.
- Async reset mid-run: x3=0xBBBBBBBB is written, then `rst_n` pulses low between clock edges → `dbg_data`(addr 3) becomes 0 immediately, before the next edge.
- Writeback integration: drive `mux_writeback` with sel 00/01/10/11 (0xAAAAAAAA/0xBBBBBBBB/0xCCCCCCCC/0xDDDDDDDD) into rd=10..13 → x10..x13 read back these values in order.
